// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I pipeline (F/D/E/M/W).
// Produces operand-forwarding selects, load-use stalls, redirect flushes,
// multi-cycle memory-stage stalls for a RAM of MEM_LAT cycles, and
// saturating performance counters for stall cycles and taken redirects.
module hazard_unit #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic [REG_AW-1:0] rs1D_i,
    input  logic [REG_AW-1:0] rs2D_i,
    input  logic [REG_AW-1:0] rs1E_i,
    input  logic [REG_AW-1:0] rs2E_i,
    input  logic [REG_AW-1:0] rdE_i,
    input  logic              regWriteE_i,
    input  logic              resultSrcE_i,
    input  logic              PCsrcE_i,
    input  logic [REG_AW-1:0] rdM_i,
    input  logic              regWriteM_i,
    input  logic              memReqM_i,
    input  logic [REG_AW-1:0] rdW_i,
    input  logic              regWriteW_i,
    output logic [1:0]        forwardAE_o,
    output logic [1:0]        forwardBE_o,
    output logic              stallF_o,
    output logic              stallD_o,
    output logic              stallE_o,
    output logic              stallM_o,
    output logic              flushD_o,
    output logic              flushE_o,
    output logic              flushW_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  redirects_o
);

    // Latency countdown only needs to hold MEM_LAT-2.
    localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam bit MEM_MULTI = (MEM_LAT > 1);
    localparam bit MEM_LONG  = (MEM_LAT > 2);
    localparam logic [CW-1:0] CNT_LOAD = (MEM_LAT > 2) ? CW'(MEM_LAT - 2) : {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(32'd1);
    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } mem_state_t;

    mem_state_t        state;
    mem_state_t        state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic              mem_stall;
    logic              lw_stall;
    logic              redirect_take;
    logic              busy_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  redir_cnt_r;

    // Forward select for one E-stage operand: M beats W, x0 never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              wr_w
    );
        logic [1:0] sel;
        if (wr_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (wr_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Operand forwarding selects for both E-stage sources.
    always_comb begin
        forwardAE_o = fwd_sel(rs1E_i, rdM_i, regWriteM_i, rdW_i, regWriteW_i);
        forwardBE_o = fwd_sel(rs2E_i, rdM_i, regWriteM_i, rdW_i, regWriteW_i);
    end

    // Load in E whose destination feeds a source of the instruction in D.
    always_comb begin
        lw_stall = resultSrcE_i && regWriteE_i && (rdE_i != REG_ZERO) &&
                   ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));
    end

    // Memory FSM state and latency counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= {CW{1'b0}};
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Memory FSM next state and memory stall; RELEASE ignores memReqM_i so
    // the instruction leaving M cannot retrigger its own stall.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (memReqM_i && MEM_MULTI) begin
                    mem_stall  = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = MEM_LONG ? BUSY : RELEASE;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (cnt == CNT_ONE) begin
                    state_next = RELEASE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = {CW{1'b0}};
            end
        endcase
    end

    // Stall/flush priority: memory stall, then redirect, then load-use.
    // A redirect during a memory stall is deferred because the PC is held.
    always_comb begin
        stallF_o      = 1'b0;
        stallD_o      = 1'b0;
        stallE_o      = 1'b0;
        stallM_o      = 1'b0;
        flushD_o      = 1'b0;
        flushE_o      = 1'b0;
        flushW_o      = 1'b0;
        redirect_take = 1'b0;
        if (mem_stall) begin
            stallF_o = 1'b1;
            stallD_o = 1'b1;
            stallE_o = 1'b1;
            stallM_o = 1'b1;
            flushW_o = 1'b1;
        end else if (PCsrcE_i) begin
            flushD_o      = 1'b1;
            flushE_o      = 1'b1;
            redirect_take = 1'b1;
        end else if (lw_stall) begin
            stallF_o = 1'b1;
            stallD_o = 1'b1;
            flushE_o = 1'b1;
        end else begin
            stallF_o = 1'b0;
        end
    end

    // Busy flag registered from the next state so it equals "FSM not IDLE".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_next != IDLE);
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (clear_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stallF_o && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_INC;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Saturating counter of redirects actually taken; clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_cnt_r <= {CNT_W{1'b0}};
        end else if (clear_i) begin
            redir_cnt_r <= {CNT_W{1'b0}};
        end else if (redirect_take && (redir_cnt_r != CNT_MAX)) begin
            redir_cnt_r <= redir_cnt_r + CNT_INC;
        end else begin
            redir_cnt_r <= redir_cnt_r;
        end
    end

    assign busy_o         = busy_r;
    assign stall_cycles_o = stall_cnt_r;
    assign redirects_o    = redir_cnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit with MEM_LAT=3 and 4-bit counters.
module tb_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = 4'hF;

    logic clk, rst, clear_i;
    logic [AW-1:0] rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i;
    logic regWriteE_i, resultSrcE_i, PCsrcE_i, regWriteM_i, memReqM_i, regWriteW_i;
    logic [1:0] forwardAE_o, forwardBE_o;
    logic stallF_o, stallD_o, stallE_o, stallM_o, flushD_o, flushE_o, flushW_o, busy_o;
    logic [CW-1:0] stall_cycles_o, redirects_o;

    hazard_unit #(.REG_AW(AW), .MEM_LAT(3), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .rs1D_i(rs1D_i), .rs2D_i(rs2D_i), .rs1E_i(rs1E_i), .rs2E_i(rs2E_i),
        .rdE_i(rdE_i), .regWriteE_i(regWriteE_i), .resultSrcE_i(resultSrcE_i),
        .PCsrcE_i(PCsrcE_i), .rdM_i(rdM_i), .regWriteM_i(regWriteM_i),
        .memReqM_i(memReqM_i), .rdW_i(rdW_i), .regWriteW_i(regWriteW_i),
        .forwardAE_o(forwardAE_o), .forwardBE_o(forwardBE_o),
        .stallF_o(stallF_o), .stallD_o(stallD_o), .stallE_o(stallE_o), .stallM_o(stallM_o),
        .flushD_o(flushD_o), .flushE_o(flushE_o), .flushW_o(flushW_o), .busy_o(busy_o),
        .stall_cycles_o(stall_cycles_o), .redirects_o(redirects_o)
    );

    // ctl bits: {stallF, stallD, stallE, stallM, flushD, flushE, flushW, busy}
    typedef struct {
        logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE;
        logic rwE, lsE, pcs;
        logic [AW-1:0] rdM;
        logic rwM, mreq;
        logic [AW-1:0] rdW;
        logic rwW, clr;
        logic [1:0] efa, efb;
        logic [7:0] ectl;
    } vec_t;

    typedef struct {
        string nm;
        logic [1:0] fa, fb;
        logic [7:0] ctl;
        logic [CW-1:0] sc, rd;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[13];
    int checks = 0;
    int errors = 0;
    logic [CW-1:0] m_sc, m_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE,
        input logic rwE, lsE, pcs,
        input logic [AW-1:0] rdM, input logic rwM, mreq,
        input logic [AW-1:0] rdW, input logic rwW, clr,
        input logic [1:0] efa, efb, input logic [7:0] ectl);
        vec_t v;
        v.rs1D = rs1D; v.rs2D = rs2D; v.rs1E = rs1E; v.rs2E = rs2E; v.rdE = rdE;
        v.rwE = rwE; v.lsE = lsE; v.pcs = pcs;
        v.rdM = rdM; v.rwM = rwM; v.mreq = mreq;
        v.rdW = rdW; v.rwW = rwW; v.clr = clr;
        v.efa = efa; v.efb = efb; v.ectl = ectl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, queue expectation, compare at
    // the falling edge, advance the counter model, move to next rising edge.
    task automatic apply(input string nm, input vec_t v);
        exp_t e;
        rs1D_i = v.rs1D; rs2D_i = v.rs2D; rs1E_i = v.rs1E; rs2E_i = v.rs2E;
        rdE_i = v.rdE; regWriteE_i = v.rwE; resultSrcE_i = v.lsE; PCsrcE_i = v.pcs;
        rdM_i = v.rdM; regWriteM_i = v.rwM; memReqM_i = v.mreq;
        rdW_i = v.rdW; regWriteW_i = v.rwW; clear_i = v.clr;
        e.nm = nm; e.fa = v.efa; e.fb = v.efb; e.ctl = v.ectl; e.sc = m_sc; e.rd = m_rd;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({e.nm, " fwd"}, {28'd0, forwardAE_o, forwardBE_o}, {28'd0, e.fa, e.fb});
        chk({e.nm, " ctl"}, {24'd0, stallF_o, stallD_o, stallE_o, stallM_o,
                             flushD_o, flushE_o, flushW_o, busy_o}, {24'd0, e.ctl});
        chk({e.nm, " cnt"}, {24'd0, stall_cycles_o, redirects_o}, {24'd0, e.sc, e.rd});
        if (v.clr) begin
            m_sc = 4'd0;
            m_rd = 4'd0;
        end else begin
            if (v.ectl[7] && m_sc != CMAX) m_sc = m_sc + 4'd1;
            if (v.ectl[3] && m_rd != CMAX) m_rd = m_rd + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t z, lw, mrq;

    initial begin
        // Single-cycle vectors: forwarding, load-use, redirect priority.
        tbl[0]  = mk(0,0,5,0,0, 0,0,0, 5,1,0, 5,1,0, 2'b10,2'b00, 8'h00);
        tbl[1]  = mk(0,0,5,0,0, 0,0,0, 5,0,0, 5,1,0, 2'b01,2'b00, 8'h00);
        tbl[2]  = mk(0,0,5,0,0, 0,0,0, 0,1,0, 0,1,0, 2'b00,2'b00, 8'h00);
        tbl[3]  = mk(0,0,0,0,0, 0,0,0, 0,1,0, 0,1,0, 2'b00,2'b00, 8'h00);
        tbl[4]  = mk(0,0,3,9,0, 0,0,0, 3,1,0, 9,1,0, 2'b10,2'b01, 8'h00);
        tbl[5]  = mk(0,7,0,0,7, 1,1,0, 0,0,0, 0,0,0, 2'b00,2'b00, 8'b1100_0100);
        tbl[6]  = mk(0,0,0,0,0, 1,1,0, 0,0,0, 0,0,0, 2'b00,2'b00, 8'h00);
        tbl[7]  = mk(4,0,0,0,4, 1,1,0, 0,0,0, 0,0,0, 2'b00,2'b00, 8'b1100_0100);
        tbl[8]  = mk(4,0,0,0,4, 1,0,0, 0,0,0, 0,0,0, 2'b00,2'b00, 8'h00);
        tbl[9]  = mk(0,7,0,0,7, 1,1,1, 0,0,0, 0,0,0, 2'b00,2'b00, 8'b0000_1100);
        tbl[10] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 2'b00,2'b00, 8'h00);
        tbl[11] = mk(0,0,0,0,0, 0,0,1, 0,0,0, 0,0,0, 2'b00,2'b00, 8'b0000_1100);
        tbl[12] = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 2'b00,2'b00, 8'h00);
        z   = tbl[12];
        lw  = tbl[5];
        mrq = z; mrq.mreq = 1'b1;

        // Reset state.
        rst = 1'b1; clear_i = 1'b0;
        rs1D_i = '0; rs2D_i = '0; rs1E_i = '0; rs2E_i = '0; rdE_i = '0; rdM_i = '0; rdW_i = '0;
        regWriteE_i = 1'b0; resultSrcE_i = 1'b0; PCsrcE_i = 1'b0;
        regWriteM_i = 1'b0; memReqM_i = 1'b0; regWriteW_i = 1'b0;
        m_sc = 4'd0; m_rd = 4'd0;
        #2;
        chk("reset ctl", {24'd0, stallF_o, stallD_o, stallE_o, stallM_o,
                          flushD_o, flushE_o, flushW_o, busy_o}, 32'd0);
        chk("reset cnt", {24'd0, stall_cycles_o, redirects_o}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // MEM_LAT=3, request held high: 2 stall cycles, release, then again.
        begin
            vec_t c;
            c = z; c.clr = 1'b1;
            apply("clr", c);
        end
        apply("mem1 idle", mk(0,0,0,0,0, 0,0,0, 0,0,1, 0,0,0, 2'b00,2'b00, 8'b1111_0010));
        apply("mem1 busy", mk(0,0,0,0,0, 0,0,0, 0,0,1, 0,0,0, 2'b00,2'b00, 8'b1111_0011));
        apply("mem1 rel",  mk(0,0,0,0,0, 0,0,0, 0,0,1, 0,0,0, 2'b00,2'b00, 8'b0000_0001));
        chk("mem stall count", {28'd0, stall_cycles_o}, 32'd2);
        apply("mem2 idle", mk(0,0,0,0,0, 0,0,0, 0,0,1, 0,0,0, 2'b00,2'b00, 8'b1111_0010));
        apply("mem2 busy", mk(0,0,0,0,0, 0,0,0, 0,0,1, 0,0,0, 2'b00,2'b00, 8'b1111_0011));
        apply("mem2 rel",  mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 2'b00,2'b00, 8'b0000_0001));
        apply("mem2 done", z);

        // Redirect and load-use during a memory stall: deferred to RELEASE.
        apply("br idle", mk(0,7,0,0,7, 1,1,1, 0,0,1, 0,0,0, 2'b00,2'b00, 8'b1111_0010));
        apply("br busy", mk(0,7,0,0,7, 1,1,1, 0,0,1, 0,0,0, 2'b00,2'b00, 8'b1111_0011));
        apply("br rel",  mk(0,7,0,0,7, 1,1,1, 0,0,0, 0,0,0, 2'b00,2'b00, 8'b0000_1101));
        apply("br done", z);
        chk("br redirect count", {28'd0, redirects_o}, 32'd1);

        // Reset asserted while BUSY, request still high after release.
        apply("rst idle", mrq.mreq ? mk(0,0,0,0,0, 0,0,0, 0,0,1, 0,0,0, 2'b00,2'b00, 8'b1111_0010) : z);
        rst = 1'b1;
        #1;
        chk("rst busy", {31'd0, busy_o}, 32'd0);
        chk("rst cnt", {24'd0, stall_cycles_o, redirects_o}, 32'd0);
        m_sc = 4'd0; m_rd = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        apply("post idle", mk(0,0,0,0,0, 0,0,0, 0,0,1, 0,0,0, 2'b00,2'b00, 8'b1111_0010));
        apply("post busy", mk(0,0,0,0,0, 0,0,0, 0,0,1, 0,0,0, 2'b00,2'b00, 8'b1111_0011));
        apply("post rel",  mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 2'b00,2'b00, 8'b0000_0001));

        // Saturation at 15 and clear priority over increment.
        for (int i = 0; i < 16; i++) apply($sformatf("sat%0d", i), lw);
        chk("sat hold", {28'd0, stall_cycles_o}, 32'd15);
        begin
            vec_t c;
            c = lw; c.clr = 1'b1;
            apply("sat clr", c);
        end
        apply("sat after clr", z);
        chk("clr result", {28'd0, stall_cycles_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
